// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one word read at a time to instruction
// memory and hands each fetched instruction with its PC to decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, req_addr, target;
    logic        squash;

    assign target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) state_nxt = (squash || redirect_valid) ? S_REQ : S_OUT;
            S_OUT:   if (redirect_valid || !stall) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_REQ) && !rst;
        imem_req_addr  = req_addr;
    end

    // Redirect outranks both response capture and stall in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            squash      <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    // The pending request is never withdrawn; its response gets dropped.
                    if (redirect_valid) begin
                        pc     <= target;
                        squash <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        squash <= 1'b0;
                        if (redirect_valid) begin
                            pc       <= target;
                            req_addr <= target;
                        end else if (squash) begin
                            req_addr <= pc;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_pc    <= req_addr;
                            instr_valid <= 1'b1;
                            pc          <= req_addr + 32'd4;
                        end
                    end else if (redirect_valid) begin
                        pc     <= target;
                        squash <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= target;
                        req_addr    <= target;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        req_addr    <= pc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a memory model plus an architectural
// model of the expected instruction stream (program order, redirects, reset).
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // knobs: 0/1 fixed, 2 random
    int          k_ready = 1, k_stall = 0, lat_cfg = 1;
    logic        k_rst = 1'b1, k_redir = 1'b0, rnd_mode = 1'b0;
    logic [31:0] k_rpc = 32'h0;

    // memory model
    logic        outst = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    // architectural model
    logic [31:0] exp_pc = RESET_PC;
    logic        first_req = 1'b1;
    int          ndel = 0, since_del = 0;
    logic [31:0] del_q[$];

    // previous-cycle snapshot
    logic        pv_rst = 0, pv_redir = 0, pv_stall = 0, pv_valid = 0;
    logic        pv_reqv = 0, pv_ready = 0;
    logic [31:0] pv_instr = 0, pv_ipc = 0, pv_addr = 0;

    task automatic step();
        logic [31:0] tgt;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (outst) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memfn(pend_addr);
                outst = 1'b0;
            end
        end else if (rnd_mode && $urandom_range(0, 9) == 0) begin
            imem_rsp_valid = 1'b1;
        end
        imem_req_ready = (k_ready == 2) ? ($urandom_range(0, 3) != 0) : (k_ready != 0);
        stall          = (k_stall == 2) ? ($urandom_range(0, 9) < 3) : (k_stall != 0);
        rst            = k_rst;
        redirect_valid = k_redir;
        redirect_pc    = k_rpc;
        if (rnd_mode && $urandom_range(0, 24) == 0) begin
            redirect_valid = 1'b1;
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                2:       redirect_pc = 32'($urandom_range(0, 255));
                default: redirect_pc = 32'hFFFF_FFFC;
            endcase
        end
        #1;

        if (pv_rst) begin
            check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_ipc", instr_pc, 32'd0);
        end else if (pv_redir) begin
            check("redir_kill", {31'd0, instr_valid}, 32'd0);
        end else if (pv_valid && pv_stall) begin
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, pv_instr);
            check("stall_ipc", instr_pc, pv_ipc);
        end else if (pv_valid) begin
            check("consumed", {31'd0, instr_valid}, 32'd0);
        end
        if (pv_reqv && !pv_ready && !pv_rst) begin
            check("req_hold", {31'd0, imem_req_valid}, 32'd1);
            check("req_addr_hold", imem_req_addr, pv_addr);
        end
        if (instr_valid === 1'b1) check("req_in_out", {31'd0, imem_req_valid}, 32'd0);

        if (rst) begin
            check("rst_reqv", {31'd0, imem_req_valid}, 32'd0);
            exp_pc    = RESET_PC;
            first_req = 1'b1;
            since_del = 0;
        end else begin
            since_del++;
            if (instr_valid && !pv_valid) begin
                check("del_pc", instr_pc, exp_pc);
                check("del_data", instr, memfn(instr_pc));
                exp_pc = instr_pc + 32'd4;
                ndel++;
                since_del = 0;
                del_q.push_back(instr_pc);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("one_outst", {31'd0, outst}, 32'd0);
                check("addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
                if (first_req) check("first_req", imem_req_addr, RESET_PC);
                first_req = 1'b0;
                outst     = 1'b1;
                pend_addr = imem_req_addr;
                cnt       = (lat_cfg == 0) ? $urandom_range(1, 3) : lat_cfg;
            end
            if (redirect_valid) begin
                tgt    = redirect_pc;
                exp_pc = {tgt[31:2], 2'b00};
            end
            if (since_del > 200) begin
                check("timeout", 32'(since_del), 32'd0);
                since_del = 0;
            end
        end

        pv_rst   = rst;       pv_redir = redirect_valid && !rst;
        pv_stall = stall;     pv_valid = instr_valid;
        pv_reqv  = imem_req_valid; pv_ready = imem_req_ready;
        pv_instr = instr;     pv_ipc   = instr_pc;  pv_addr = imem_req_addr;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_once(input logic [31:0] pc);
        k_redir = 1'b1; k_rpc = pc;
        del_q.delete();
        step();
        k_redir = 1'b0;
    endtask

    initial begin
        int n0, i;
        // 1: reset then free-running fetch, one instruction per 3 cycles
        run(2);
        k_rst = 1'b0;
        n0 = ndel;
        del_q.delete();
        run(9);
        check("thruput", 32'(ndel - n0), 32'd3);
        check("seq_pc2", (del_q.size() > 2) ? del_q[2] : 32'hDEAD, 32'h8);

        // 2: stall holds the presented instruction
        k_stall = 1;
        for (i = 0; i < 50 && !instr_valid; i++) step();
        check("reach_out", {31'd0, instr_valid}, 32'd1);
        run(5);
        k_stall = 0;
        run(2);

        // 3: memory not ready for 4 cycles
        k_ready = 0;
        for (i = 0; i < 50 && !imem_req_valid; i++) step();
        run(4);
        k_ready = 1;
        run(3);

        // 4: redirect while waiting on a slow response
        lat_cfg = 3;
        for (i = 0; i < 50 && !outst; i++) step();
        check("reach_wait", {31'd0, outst}, 32'd1);
        redirect_once(32'h103);
        run(20);
        check("redir_wait0", (del_q.size() > 0) ? del_q[0] : 32'hDEAD, 32'h100);
        check("redir_wait1", (del_q.size() > 1) ? del_q[1] : 32'hDEAD, 32'h104);

        // 5a: redirect while presenting under stall
        lat_cfg = 1;
        k_stall = 1;
        for (i = 0; i < 50 && !instr_valid; i++) step();
        redirect_once(32'h200);
        k_stall = 0;
        run(8);
        check("redir_out", (del_q.size() > 0) ? del_q[0] : 32'hDEAD, 32'h200);

        // 5b: redirect in the same cycle as the response
        lat_cfg = 2;
        for (i = 0; i < 50 && !(outst && cnt == 1); i++) step();
        check("reach_rsp", {31'd0, outst}, 32'd1);
        redirect_once(32'h302);
        run(10);
        check("redir_rsp", (del_q.size() > 0) ? del_q[0] : 32'hDEAD, 32'h300);

        // 6a: reset during WAIT; the late response lands while in reset
        lat_cfg = 3;
        for (i = 0; i < 50 && !outst; i++) step();
        k_rst = 1'b1;
        run(4);
        k_rst = 1'b0;
        del_q.delete();
        run(10);
        check("post_rst", (del_q.size() > 0) ? del_q[0] : 32'hDEAD, RESET_PC);

        // 6b: PC wrap from the top of the address space
        lat_cfg = 1;
        redirect_once(32'hFFFF_FFFE);
        run(12);
        check("wrap0", (del_q.size() > 0) ? del_q[0] : 32'hDEAD, 32'hFFFF_FFFC);
        check("wrap1", (del_q.size() > 1) ? del_q[1] : 32'hDEAD, 32'h0);

        // random phase
        rnd_mode = 1'b1; lat_cfg = 0; k_ready = 2; k_stall = 2;
        n0 = 0;
        for (int c = 0; c < 4000; c++) begin
            if (n0 > 0) begin k_rst = 1'b1; n0--; end
            else if ($urandom_range(0, 299) == 0) begin k_rst = 1'b1; n0 = 3; end
            else k_rst = 1'b0;
            step();
        end
        k_rst = 1'b0; rnd_mode = 1'b0;
        run(20);
        check("rnd_progress", {31'd0, ndel > 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
